// File: rtl/key_debounce_multi.sv
// Multi-channel push-button debouncer: each channel has its own synchroniser,
// debounce counter and hold-time FSM producing level, press/release, long and repeat strobes.
module key_debounce_multi #(
    parameter int KEY_NUM    = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DELAY_CNT  = 999999,
    parameter int CNT_W      = 20,
    parameter int LONG_CYC   = 50000000,
    parameter int REPEAT_CYC = 10000000,
    parameter int HOLD_W     = 26
) (
    input  logic               s_clk,
    input  logic               s_rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long,
    output logic [KEY_NUM-1:0] key_repeat
);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        RPT
    } hold_state_e;

    localparam logic              IDLE_PIN  = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  DELAY_MAX = CNT_W'(DELAY_CNT);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);

    for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
        logic              sync1_q;
        logic              smp_q;
        logic              stb_q,     stb_d;
        logic [CNT_W-1:0]  cnt_q,     cnt_d;
        logic              level_q,   level_d;
        logic              press_q,   press_d;
        logic              release_q, release_d;
        logic              long_q,    long_d;
        logic              repeat_q,  repeat_d;
        hold_state_e       state_q,   state_d;
        logic [HOLD_W-1:0] hold_q,    hold_d;

        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
        always_comb begin
            stb_d = stb_q;
            cnt_d = '0;
            if (smp_q != stb_q) begin
                if (cnt_q == DELAY_MAX) begin
                    stb_d = smp_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Level is registered one cycle behind stb so the edge strobes line up with it.
        assign level_d   = stb_q ^ IDLE_PIN;
        assign press_d   = level_d & ~level_q;
        assign release_d = ~level_d & level_q;

        always_comb begin
            state_d  = state_q;
            hold_d   = hold_q;
            long_d   = 1'b0;
            repeat_d = 1'b0;
            case (state_q)
                IDLE: begin
                    hold_d = '0;
                    if (press_d) begin
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (!level_d) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (hold_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        hold_d  = '0;
                        state_d = RPT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RPT: begin
                    // Release wins over any strobe that would fall in the same cycle.
                    if (!level_d) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (REPEAT_CYC != 0) begin
                        if (hold_q == REP_LAST) begin
                            repeat_d = 1'b1;
                            hold_d   = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        always_ff @(posedge s_clk or posedge s_rst) begin
            if (s_rst) begin
                sync1_q   <= IDLE_PIN;
                smp_q     <= IDLE_PIN;
                stb_q     <= IDLE_PIN;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                state_q   <= IDLE;
                hold_q    <= '0;
            end else begin
                sync1_q   <= key_in[g];
                smp_q     <= sync1_q;
                stb_q     <= stb_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
                repeat_q  <= repeat_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
        assign key_long[g]    = long_q;
        assign key_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: directed scenarios plus random pin activity,
// compared every cycle against a window/timestamp model of the debouncer.
module tb_key_debounce_multi;

    localparam int KN   = 2;
    localparam int D    = 9;
    localparam int LONG = 40;
    localparam int REP  = 16;

    logic          s_clk;
    logic          s_rst;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_level;
    logic [KN-1:0] key_press;
    logic [KN-1:0] key_release;
    logic [KN-1:0] key_long;
    logic [KN-1:0] key_repeat;

    key_debounce_multi #(
        .KEY_NUM   (KN),
        .ACTIVE_LOW(1),
        .DELAY_CNT (D),
        .CNT_W     (4),
        .LONG_CYC  (LONG),
        .REPEAT_CYC(REP),
        .HOLD_W    (6)
    ) dut (
        .s_clk      (s_clk),
        .s_rst      (s_rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_repeat (key_repeat)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: last D+2 pin samples per channel, the stable pin level,
    // and the edge number of the most recent debounced press.
    bit            hist [KN][D+2];
    bit            stb_m   [KN];
    bit            lvl_m   [KN];
    bit            pvalid  [KN];
    int            press_e [KN];
    int            edge_n;
    logic [KN-1:0] e_lvl, e_prs, e_rel, e_lng, e_rpt;
    bit            saw_long0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < KN; c++) begin
            for (int i = 0; i < D + 2; i++) hist[c][i] = 1'b1;
            stb_m[c]  = 1'b1;
            lvl_m[c]  = 1'b0;
            pvalid[c] = 1'b0;
            press_e[c] = 0;
        end
        e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
    endtask

    // One rising edge: the pin value sampled at this edge is p.
    task automatic model_edge(input logic [KN-1:0] p);
        edge_n++;
        for (int c = 0; c < KN; c++) begin
            bit new_lvl;
            bit flip;
            int d;
            new_lvl  = ~stb_m[c];
            e_lvl[c] = new_lvl;
            e_prs[c] = new_lvl & ~lvl_m[c];
            e_rel[c] = ~new_lvl & lvl_m[c];
            if (e_prs[c]) begin
                press_e[c] = edge_n;
                pvalid[c]  = 1'b1;
            end
            if (!new_lvl) pvalid[c] = 1'b0;
            d = edge_n - press_e[c];
            e_lng[c] = new_lvl && pvalid[c] && (d == LONG);
            e_rpt[c] = new_lvl && pvalid[c] && (d > LONG) && ((d - LONG) % REP == 0);
            lvl_m[c] = new_lvl;
            // The stable level flips once the synchronised pin has disagreed with it for D+1 samples.
            flip = 1'b1;
            for (int i = 1; i <= D + 1; i++) if (hist[c][i] == stb_m[c]) flip = 1'b0;
            if (flip) stb_m[c] = ~stb_m[c];
            for (int i = D + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = p[c];
        end
    endtask

    task automatic step();
        logic [KN-1:0] p;
        logic          r;
        @(posedge s_clk);
        p = key_in;
        r = s_rst;
        #1;
        if (r) model_reset();
        else   model_edge(p);
        check("level",   32'(key_level),   32'(e_lvl));
        check("press",   32'(key_press),   32'(e_prs));
        check("release", 32'(key_release), 32'(e_rel));
        check("long",    32'(key_long),    32'(e_lng));
        check("repeat",  32'(key_repeat),  32'(e_rpt));
        if (key_long[0]) saw_long0 = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'({key_level, key_press, key_release, key_long, key_repeat}), 32'd0);
    endtask

    // Asynchronous reset asserted between clock edges, held for a few edges.
    task automatic async_reset(input int hold_cycles);
        #3;
        s_rst = 1'b1;
        #1;
        check_all_zero("async_rst_outputs");
        model_reset();
        steps(hold_cycles);
        s_rst = 1'b0;
    endtask

    initial begin
        int dur [KN];
        int rel_cnt;

        s_rst     = 1'b1;
        key_in    = 2'b11;
        edge_n    = 0;
        saw_long0 = 1'b0;
        model_reset();
        steps(3);
        check_all_zero("reset_state");
        s_rst = 1'b0;
        steps(5);

        // Clean press on key 0, held briefly, then released: no long press.
        key_in = 2'b10;
        steps(12);
        check("t1_level_before", 32'(key_level), 32'd0);
        step();
        check("t1_press", 32'(key_press), 32'b01);
        check("t1_level", 32'(key_level), 32'b01);
        step();
        check("t1_press_one_cycle", 32'(key_press), 32'd0);
        steps(18);
        key_in = 2'b11;
        steps(12);
        step();
        check("t4_release", 32'(key_release), 32'b01);
        steps(10);
        check("t4_no_long", 32'(saw_long0), 32'd0);

        // Bounce shorter than the window never changes the level.
        key_in[0] = 1'b0; steps(5);
        key_in[0] = 1'b1; steps(3);
        key_in[0] = 1'b0; steps(4);
        key_in[0] = 1'b1; steps(3);
        check("t2_no_level", 32'(key_level), 32'd0);
        key_in[0] = 1'b0;
        steps(12);
        step();
        check("t2_press", 32'(key_press), 32'b01);

        // Long press and auto-repeat relative to the press cycle.
        for (int i = 1; i <= 100; i++) begin
            step();
            check("t3_long", 32'(key_long[0]), 32'(i == 40));
            check("t3_repeat", 32'(key_repeat[0]), 32'(i == 56 || i == 72 || i == 88));
        end
        key_in[0] = 1'b1;
        rel_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            rel_cnt += int'(key_release[0]);
        end
        check("t3_release_once", 32'(rel_cnt), 32'd1);

        // Both keys pressed together; key 1 released while key 0 goes long.
        key_in = 2'b00;
        steps(12);
        step();
        check("t5_press_both", 32'(key_press), 32'b11);
        steps(5);
        key_in = 2'b10;
        steps(12);
        step();
        check("t5_release_key1", 32'(key_release), 32'b10);
        steps(21);
        step();
        check("t5_long_key0", 32'(key_long), 32'b01);

        // Reset while key 0 sits in the repeat phase, key still held afterwards.
        steps(5);
        async_reset(3);
        rel_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            rel_cnt += int'(key_release[0]) + int'(key_release[1]);
        end
        check("t6_no_release", 32'(rel_cnt), 32'd0);
        step();
        check("t6_press_after_reset", 32'(key_press), 32'b01);
        key_in = 2'b11;
        steps(30);

        // Random pin activity: short bounces mixed with long holds, one reset midway.
        for (int c = 0; c < KN; c++) dur[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < KN; c++) begin
                if (dur[c] == 0) begin
                    key_in[c] = ~key_in[c];
                    dur[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8))
                                                          : int'($urandom_range(10, 120));
                end else begin
                    dur[c]--;
                end
            end
            step();
            if (cyc == 1500) async_reset(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel key debouncer. It generalises the single-shared-counter debounce used in front of the IIC write/read control.
- Each key channel has its own synchroniser, its own debounce counter and its own hold-time FSM.
- Per channel it produces a debounced level plus single-cycle press, release, long-press and auto-repeat strobes.
- It sits between board push-buttons and command logic, for example EEPROM write/read triggers and value increment/decrement.

Parameters:
- KEY_NUM, 4: number of independent key channels (1..16).
- ACTIVE_LOW, 1: 1 means a key reads 0 when pressed; 0 means a key reads 1 when pressed.
- DELAY_CNT, 999999: debounce window terminal count, 20 ms at 50 MHz.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DELAY_CNT.
- LONG_CYC, 50000000: cycles of stable press before the long-press strobe (1 s).
- REPEAT_CYC, 10000000: auto-repeat period after a long press; 0 disables repeat.
- HOLD_W, 26: hold counter width; must hold max(LONG_CYC, REPEAT_CYC).

Ports:
- s_clk, input, 1: system clock.
- s_rst, input, 1: reset.
- key_in, input, KEY_NUM: raw asynchronous key pins.
- key_level, output, KEY_NUM: debounced pressed state, 1 = pressed.
- key_press, output, KEY_NUM: 1-cycle strobe on a debounced press.
- key_release, output, KEY_NUM: 1-cycle strobe on a debounced release.
- key_long, output, KEY_NUM: 1-cycle strobe when a press reaches LONG_CYC.
- key_repeat, output, KEY_NUM: 1-cycle strobe every REPEAT_CYC cycles after key_long, while still held.

Interface (already decided): one clock; reset is asynchronous and active-high (s_clk, s_rst).

Behaviour:

Reset
- All state is asynchronously forced to the released state.
- Synchroniser flops reset to the inactive pin level (ACTIVE_LOW ? 1 : 0).
- All counters reset to 0; FSMs reset to IDLE.
- All outputs reset to 0.
- Reset mid-hold: no release or other strobe is generated, either on entry to reset or after it.

Synchroniser
- 2-flop synchroniser per channel. The second stage is the sample `smp`.
- `stb` is the per-channel stable register.

Debounce, per channel, independent
- If smp == stb: cnt <= 0.
- Else if cnt == DELAY_CNT: stb <= smp and cnt <= 0.
- Else: cnt <= cnt + 1.
- Any bounce that returns smp to stb clears cnt. A pulse shorter than DELAY_CNT+1 cycles therefore never changes stb.
- Latency: a clean pin edge sampled at edge 0 changes key_level at edge DELAY_CNT+3.

Outputs and strobes
- key_level = stb XOR ACTIVE_LOW.
- key_press and key_release are registered. Each is asserted in the cycle where key_level first shows its new value, for exactly 1 cycle.

Hold FSM, per channel, 3 states
- IDLE: hold_cnt = 0. On a debounced press go to HELD, in the same cycle key_press asserts.
- HELD: hold_cnt increments each cycle.
  - When hold_cnt == LONG_CYC-1: key_long asserts next cycle, hold_cnt <= 0, go to RPT.
  - On release: go to IDLE, no key_long.
- RPT:
  - If REPEAT_CYC != 0: hold_cnt counts; when hold_cnt == REPEAT_CYC-1, key_repeat asserts next cycle and hold_cnt wraps to 0.
  - If REPEAT_CYC == 0: stay in RPT silently.
  - On release: go to IDLE.
- key_long timing: key_long asserts exactly LONG_CYC cycles after key_press.
- key_repeat timing: the first key_repeat comes REPEAT_CYC cycles after key_long, then every REPEAT_CYC cycles.
- Release in any state asserts key_release. On that cycle no long or repeat strobe asserts; release has priority.

Channel independence and counter widths
- Channels are fully independent. Simultaneous events on several channels produce simultaneous strobes on the corresponding bits.
- Counters never wrap: the debounce counter is bounded by DELAY_CNT and the hold counter by LONG_CYC/REPEAT_CYC.

Test Plan:
Bench configuration: KEY_NUM=2, ACTIVE_LOW=1, DELAY_CNT=9, LONG_CYC=40, REPEAT_CYC=16.

1. Clean press: key_in[0] goes 1→0 at edge 0.
   - key_level[0] rises at edge 12.
   - key_press[0] is high for exactly that cycle.
   - key_in[1] channel is unaffected.
2. Bounce: key_in[0] toggles low 5 cycles, high 3 cycles, low 4 cycles, then high.
   - No key_level change and no strobes.
   - A 12-cycle stable low after the bounce produces key_press 12 cycles after the last edge.
3. Long press and repeat: hold key 0 for 100 cycles after key_press.
   - key_long at +40 from key_press.
   - key_repeat at +56, +72, +88 from key_press.
   - On release: key_release once; no long or repeat strobe in the release cycle.
4. Short press: press held 20 cycles after debounce, then released.
   - key_press and key_release only; key_long never asserts.
5. Simultaneous: both keys pressed on the same edge.
   - key_press = 2'b11 in the same cycle.
   - Release only key 1: key_release = 2'b10, while key 0 continues to its long press.
6. Reset mid-hold: assert s_rst asynchronously during the RPT state, between clock edges.
   - All outputs are 0 immediately.
   - After deassertion with the key still held: a new key_press arrives after 12 cycles.
   - No spurious key_release at any point.
